// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush-to-bubble and saturating perf counters.
// Optional two-entry skid buffer enabled by defining PIPE_SKID_EN; default build is a single-entry register.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 24,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic en);
    if (en && (cnt != {CNT_W{1'b1}})) return cnt + CNT_W'(1);
    return cnt;
  endfunction

  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic [CTRL_W-1:0] ctrl_p1;
  logic              accept;

  assign accept = in_valid & in_ready;

`ifdef PIPE_SKID_EN
  logic              vld_p0;
  logic [DATA_W-1:0] data_p0;
  logic [CTRL_W-1:0] ctrl_p0;

  // in_ready depends only on registered skid state, never on out_ready
  assign in_ready = ~rst & ~vld_p0;

  // stage p0 (skid) -> p1 (output)
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      ctrl_p0 <= '0;
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
      data_p1 <= '0;
    end else if (flush) begin
      vld_p0  <= 1'b0;
      ctrl_p0 <= '0;
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
    end else if (~vld_p1 | out_ready) begin
      if (vld_p0) begin
        vld_p1  <= 1'b1;
        data_p1 <= data_p0;
        ctrl_p1 <= ctrl_p0;
        vld_p0  <= 1'b0;
        ctrl_p0 <= '0;
      end else if (accept) begin
        vld_p1  <= 1'b1;
        data_p1 <= in_data;
        ctrl_p1 <= in_ctrl;
      end else begin
        vld_p1  <= 1'b0;
        ctrl_p1 <= '0;
      end
    end else if (accept) begin
      // output is stalled: park the accepted word in the skid entry
      vld_p0  <= 1'b1;
      data_p0 <= in_data;
      ctrl_p0 <= in_ctrl;
    end
  end
`else
  assign in_ready = ~rst & (~vld_p1 | out_ready);

  // stage in -> p1 (output)
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
      data_p1 <= '0;
    end else if (flush) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      data_p1 <= in_data;
      ctrl_p1 <= in_ctrl;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
    end
  end
`endif

  // performance counters, sampled on the pre-edge output state
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      stall_cnt  <= sat_inc(stall_cnt, vld_p1 & ~out_ready);
      bubble_cnt <= sat_inc(bubble_cnt, ~vld_p1);
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_ctrl  = ctrl_p1;

endmodule
